// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: H/V counters with registered decodes.
// Optional frame counter enabled by defining VIDEO_TIMING_GEN_FRAME_CNT_EN.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned H_FP     = 88,
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_BP     = 148,
  parameter int unsigned V_ACTIVE = 1080,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 36,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned HW       = 12,
  parameter int unsigned VW       = 11
) (
  input  logic          iCLK,
  input  logic          reset,
  input  logic          en,
  output logic [HW-1:0] HCNT,
  output logic [VW-1:0] VCNT,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          sof,
  output logic          eol,
  output logic [15:0]   frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_MAX  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_MAX  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
    $error("video_timing_gen: zero-length active/porch/sync region");
  end
  if (longint'(H_TOTAL) > (longint'(1) << HW) ||
      longint'(V_TOTAL) > (longint'(1) << VW)) begin : g_bad_width
    $error("video_timing_gen: totals do not fit HW/VW");
  end

  logic [HW-1:0] r_hcnt, w_hnext;
  logic [VW-1:0] r_vcnt, w_vnext;
  logic          w_hwrap, w_de, w_hs, w_vs, w_sof, w_eol;
  logic [HW-1:0] w_x;
  logic [VW-1:0] w_y;
  logic          r_hs, r_vs, r_de, r_sof, r_eol;
  logic [HW-1:0] r_x;
  logic [VW-1:0] r_y;

  // Decodes look at the next position so every flop moves on the same edge.
  always_comb begin
    w_hwrap = (r_hcnt == H_MAX);
    w_hnext = w_hwrap ? '0 : r_hcnt + 1'b1;
    w_vnext = r_vcnt;
    if (w_hwrap) w_vnext = (r_vcnt == V_MAX) ? '0 : r_vcnt + 1'b1;
    w_de  = (w_hnext < H_ACT) && (w_vnext < V_ACT);
    w_hs  = (w_hnext >= H_SS && w_hnext < H_SE) ? HS_POL : ~HS_POL;
    w_vs  = (w_vnext >= V_SS && w_vnext < V_SE) ? VS_POL : ~VS_POL;
    w_x   = w_de ? w_hnext : '0;
    w_y   = w_de ? w_vnext : '0;
    w_sof = (w_hnext == '0) && (w_vnext == '0);
    w_eol = (w_hnext == H_LAST) && (w_vnext < V_ACT);
  end

  always_ff @(posedge iCLK) begin
    if (reset) begin
      r_hcnt <= H_MAX;
      r_vcnt <= V_MAX;
      r_hs   <= ~HS_POL;
      r_vs   <= ~VS_POL;
      r_de   <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
      r_sof  <= 1'b0;
      r_eol  <= 1'b0;
    end else if (en) begin
      r_hcnt <= w_hnext;
      r_vcnt <= w_vnext;
      r_hs   <= w_hs;
      r_vs   <= w_vs;
      r_de   <= w_de;
      r_x    <= w_x;
      r_y    <= w_y;
      r_sof  <= w_sof;
      r_eol  <= w_eol;
    end
  end

`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge iCLK) begin
    if (reset) r_frame_cnt <= '0;
    else if (en && w_sof) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = 16'd0;
`endif

  assign HCNT  = r_hcnt;
  assign VCNT  = r_vcnt;
  assign hsync = r_hs;
  assign vsync = r_vs;
  assign de    = r_de;
  assign x     = r_x;
  assign y     = r_y;
  assign sof   = r_sof;
  assign eol   = r_eol;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: random en/reset against a pixel-index model,
// two instances with opposite sync polarity on the small 16x8 format.
module tb_video_timing_gen;

  localparam int HT = 16;
  localparam int VT = 8;
  localparam int NPIX = HT * VT;

  logic iCLK = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;

  always #5 iCLK = ~iCLK;

  logic [3:0] a_hc, b_hc, a_x, b_x;
  logic [2:0] a_vc, b_vc, a_y, b_y;
  logic a_hs, b_hs, a_vs, b_vs, a_de, b_de;
  logic a_sof, b_sof, a_eol, b_eol;
  logic [15:0] a_fc, b_fc;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .HW(4), .VW(3)
  ) u_pos (
    .iCLK(iCLK), .reset(reset), .en(en),
    .HCNT(a_hc), .VCNT(a_vc), .hsync(a_hs), .vsync(a_vs),
    .de(a_de), .x(a_x), .y(a_y), .sof(a_sof), .eol(a_eol),
    .frame_cnt(a_fc)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .HW(4), .VW(3)
  ) u_neg (
    .iCLK(iCLK), .reset(reset), .en(en),
    .HCNT(b_hc), .VCNT(b_vc), .hsync(b_hs), .vsync(b_vs),
    .de(b_de), .x(b_x), .y(b_y), .sof(b_sof), .eol(b_eol),
    .frame_cnt(b_fc)
  );

  int n_tests = 0;
  int n_fail = 0;

  // Model: linear pixel index within the frame; reset parks it on the last pixel.
  int p = NPIX - 1;
  logic [15:0] m_fc = '0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d p=%0d t=%0t", tag, got, exp, p, $time);
    end
  endtask

  task automatic chk_inst(
    input string n, input bit pol,
    input int hc, input int vc, input int hs, input int vs,
    input int de_o, input int xo, input int yo,
    input int sof_o, input int eol_o, input int fc
  );
    int h, v, e_de, e_fc;
    h = p % HT;
    v = p / HT;
    e_de = (h < 8 && v < 4) ? 1 : 0;
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    e_fc = int'(m_fc);
`else
    e_fc = 0;
`endif
    chk({n, ".hcnt"}, hc, h);
    chk({n, ".vcnt"}, vc, v);
    chk({n, ".hsync"}, hs, int'((h >= 10 && h <= 12) ? pol : !pol));
    chk({n, ".vsync"}, vs, int'((v >= 5 && v <= 6) ? pol : !pol));
    chk({n, ".de"}, de_o, e_de);
    chk({n, ".x"}, xo, e_de ? h : 0);
    chk({n, ".y"}, yo, e_de ? v : 0);
    chk({n, ".sof"}, sof_o, (p == 0) ? 1 : 0);
    chk({n, ".eol"}, eol_o, (h == 7 && v < 4) ? 1 : 0);
    chk({n, ".frame_cnt"}, fc, e_fc);
  endtask

  task automatic step(input bit r, input bit e);
    @(negedge iCLK);
    reset = r;
    en = e;
    @(posedge iCLK);
    #1;
    if (r) begin
      p = NPIX - 1;
      m_fc = '0;
    end else if (e) begin
      p = (p + 1) % NPIX;
      if (p == 0) m_fc = m_fc + 16'd1;
    end
    chk_inst("pos", 1'b1, a_hc, a_vc, a_hs, a_vs, a_de, a_x, a_y,
             a_sof, a_eol, a_fc);
    chk_inst("neg", 1'b0, b_hc, b_vc, b_hs, b_vs, b_de, b_x, b_y,
             b_sof, b_eol, b_fc);
  endtask

  task automatic run_to(input int target);
    int k;
    k = 0;
    while (p != target && k < 2 * NPIX) begin
      step(1'b0, 1'b1);
      k++;
    end
    chk("run_to_reached", p, target);
  endtask

  initial begin
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("first_sof", int'(a_sof), 1);
    for (int i = 0; i < 3 * NPIX + 5; i++) step(1'b0, 1'b1);

    run_to(6);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("resume_eol", int'(a_eol), 1);

    run_to(2 * HT + 9);
    step(1'b1, 1'b0);
    chk("midframe_rst_hcnt", int'(a_hc), 15);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 399) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
